rvc_asap_dmem_rsp: RTL and testbench

Data-memory responder for the rvc_asap core: the memory end of the core's load/store interface. It accepts word, half and byte requests over a valid/ready handshake and performs the write or read against an internal byte array. Read data is sign- or zero-extended, and each response is returned after a parameterised latency over a second valid/ready handshake. It replaces the async-read D_MEM so the core can move to a pipelined, back-pressured memory.

---
 rtl/rvc_asap_dmem_rsp.sv | 198 +++++++++++++++++++
 tb/tb_rvc_asap_dmem_rsp.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvc_asap_dmem_rsp.sv
// Data-memory responder for rvc_asap: a byte array behind a request/response
// valid/ready pair with a fixed-latency pipeline and an in-order response FIFO.
module rvc_asap_dmem_rsp #(
    parameter int unsigned DMEM_BYTES = 4096,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned MAX_OUT    = LATENCY + 1
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddr,
    input  logic [3:0]  ReqByteEn,
    input  logic [31:0] ReqWrData,
    input  logic        ReqSignExt,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspRdData,
    output logic        RspError
);

    localparam int unsigned AW = $clog2(DMEM_BYTES);
    localparam int unsigned CW = $clog2(MAX_OUT + 1);
    localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [7:0]    r_mem [DMEM_BYTES];

    logic [2:0]    w_size;
    logic          w_aligned;
    logic [32:0]   w_end;
    logic          w_legal;
    logic          w_req_fire;
    logic          w_pop;
    logic [AW-1:0] w_idx;
    logic [7:0]    w_byte [4];
    logic          w_fill;
    logic [31:0]   w_ld_data;
    logic [31:0]   w_rsp_data;
    logic          w_rsp_err;

    logic          w_push;
    logic [31:0]   w_push_data;
    logic          w_push_err;

    logic [31:0]   r_fd [MAX_OUT];
    logic          r_fe [MAX_OUT];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_fcnt;
    logic [CW-1:0] r_out;
    logic [CW-1:0] w_out_next;
    logic          r_ready;

    // Request decode: access size from the enable pattern, then alignment.
    always_comb begin
        w_size    = '0;
        w_aligned = 1'b0;
        case (ReqByteEn)
            4'b0001: begin w_size = 3'd1; w_aligned = 1'b1;                  end
            4'b0011: begin w_size = 3'd2; w_aligned = ~ReqAddr[0];           end
            4'b1111: begin w_size = 3'd4; w_aligned = (ReqAddr[1:0] == 2'b00); end
            default: ;
        endcase
    end

    assign w_end      = {1'b0, ReqAddr} + {30'd0, w_size};
    assign w_legal    = w_aligned && (w_end <= 33'(DMEM_BYTES));
    assign w_req_fire = ReqValid && ReqReady;
    assign w_pop      = RspValid && RspReady;
    assign w_idx      = ReqAddr[AW-1:0];

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            w_byte[i] = r_mem[w_idx + AW'(i)];
        end
    end

    always_comb begin
        w_ld_data = '0;
        w_fill    = 1'b0;
        case (w_size)
            3'd1: begin
                w_fill    = ReqSignExt & w_byte[0][7];
                w_ld_data = {{24{w_fill}}, w_byte[0]};
            end
            3'd2: begin
                w_fill    = ReqSignExt & w_byte[1][7];
                w_ld_data = {{16{w_fill}}, w_byte[1], w_byte[0]};
            end
            3'd4: w_ld_data = {w_byte[3], w_byte[2], w_byte[1], w_byte[0]};
            default: ;
        endcase
    end

    assign w_rsp_data = (ReqWrite || !w_legal) ? '0 : w_ld_data;
    assign w_rsp_err  = ~w_legal;

    // Array is deliberately not reset; ReqReady is low in reset so nothing fires.
    always_ff @(posedge Clock) begin
        if (w_req_fire && ReqWrite && w_legal) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (ReqByteEn[i]) begin
                    r_mem[w_idx + AW'(i)] <= ReqWrData[8*i +: 8];
                end
            end
        end
    end

    // The FIFO write is the final latency stage, so only LATENCY-1 registers precede it.
    generate
        if (LATENCY == 1) begin : g_direct
            assign w_push      = w_req_fire;
            assign w_push_data = w_rsp_data;
            assign w_push_err  = w_rsp_err;
        end else begin : g_pipe
            logic        r_pv [LATENCY-1];
            logic [31:0] r_pd [LATENCY-1];
            logic        r_pe [LATENCY-1];

            always_ff @(posedge Clock or negedge Rst) begin
                if (!Rst) begin
                    for (int unsigned i = 0; i < LATENCY - 1; i++) begin
                        r_pv[i] <= 1'b0;
                        r_pd[i] <= '0;
                        r_pe[i] <= 1'b0;
                    end
                end else begin
                    r_pv[0] <= w_req_fire;
                    r_pd[0] <= w_rsp_data;
                    r_pe[0] <= w_rsp_err;
                    for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                        r_pv[i] <= r_pv[i-1];
                        r_pd[i] <= r_pd[i-1];
                        r_pe[i] <= r_pe[i-1];
                    end
                end
            end

            assign w_push      = r_pv[LATENCY-2];
            assign w_push_data = r_pd[LATENCY-2];
            assign w_push_err  = r_pe[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_fd[r_wp] <= w_push_data;
            r_fe[r_wp] <= w_push_err;
        end
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= (r_wp == PW'(MAX_OUT - 1)) ? '0 : r_wp + PW'(1);
            end
            if (w_pop) begin
                r_rp <= (r_rp == PW'(MAX_OUT - 1)) ? '0 : r_rp + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + CW'(1);
                2'b01:   r_fcnt <= r_fcnt - CW'(1);
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    assign RspValid  = (r_fcnt != '0);
    assign RspRdData = RspValid ? r_fd[r_rp] : '0;
    assign RspError  = RspValid ? r_fe[r_rp] : 1'b0;

    always_comb begin
        case ({w_req_fire, w_pop})
            2'b10:   w_out_next = r_out + CW'(1);
            2'b01:   w_out_next = r_out - CW'(1);
            default: w_out_next = r_out;
        endcase
    end

    // Ready is registered from the next outstanding count to keep it off any input path.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            r_out   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_out   <= w_out_next;
            r_ready <= (w_out_next < CW'(MAX_OUT));
        end
    end

    assign ReqReady = r_ready;

endmodule

// File: tb/tb_rvc_asap_dmem_rsp.sv
// Self-checking bench for rvc_asap_dmem_rsp: directed table plus random traffic
// on a LATENCY=1 instance (index 0) and a LATENCY=2 instance (index 1).
module tb_rvc_asap_dmem_rsp;

    localparam int unsigned DB = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [2];
    logic        rq_v   [2];
    logic        rq_rdy [2];
    logic        rq_w   [2];
    logic [31:0] rq_a   [2];
    logic [3:0]  rq_be  [2];
    logic [31:0] rq_d   [2];
    logic        rq_sx  [2];
    logic        rs_v   [2];
    logic        rs_r   [2];
    logic [31:0] rs_d   [2];
    logic        rs_e   [2];

    rvc_asap_dmem_rsp #(.DMEM_BYTES(DB), .LATENCY(1), .MAX_OUT(2)) u_a (
        .Clock(clk), .Rst(rst[0]), .ReqValid(rq_v[0]), .ReqReady(rq_rdy[0]),
        .ReqWrite(rq_w[0]), .ReqAddr(rq_a[0]), .ReqByteEn(rq_be[0]),
        .ReqWrData(rq_d[0]), .ReqSignExt(rq_sx[0]), .RspValid(rs_v[0]),
        .RspReady(rs_r[0]), .RspRdData(rs_d[0]), .RspError(rs_e[0])
    );

    rvc_asap_dmem_rsp #(.DMEM_BYTES(DB), .LATENCY(2), .MAX_OUT(3)) u_b (
        .Clock(clk), .Rst(rst[1]), .ReqValid(rq_v[1]), .ReqReady(rq_rdy[1]),
        .ReqWrite(rq_w[1]), .ReqAddr(rq_a[1]), .ReqByteEn(rq_be[1]),
        .ReqWrData(rq_d[1]), .ReqSignExt(rq_sx[1]), .RspValid(rs_v[1]),
        .RspReady(rs_r[1]), .RspRdData(rs_d[1]), .RspError(rs_e[1])
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    bit   chk_lat [2];
    logic [7:0] mm [2][DB];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference: size/alignment/range rules applied with plain arithmetic on a byte array.
    function automatic void model(input int s, input logic w, input logic [31:0] a,
                                  input logic [3:0] be, input logic [31:0] d, input logic sx,
                                  output logic [31:0] rd, output logic er);
        int unsigned sz;
        longint unsigned v;
        sz = (be == 4'b0001) ? 1 : (be == 4'b0011) ? 2 : (be == 4'b1111) ? 4 : 0;
        rd = '0;
        er = 1'b1;
        if (sz == 0) return;
        if ((a % sz) != 0) return;
        if (longint'(a) + longint'(sz) > longint'(DB)) return;
        er = 1'b0;
        if (w) begin
            for (int unsigned i = 0; i < sz; i++) mm[s][a + i] = d[8*i +: 8];
            return;
        end
        v = 0;
        for (int unsigned i = 0; i < sz; i++) v += longint'(mm[s][a + i]) << (8 * i);
        if (sx && v[8*sz-1]) v = v | ~((64'd1 << (8 * sz)) - 1);
        rd = v[31:0];
    endfunction

    task automatic mon(input int s);
        exp_t x;
        logic [31:0] rd;
        logic er;
        int qs;
        if (!rst[s]) begin
            if (s == 0) q0.delete(); else q1.delete();
            return;
        end
        if (rs_v[s] && rs_r[s]) begin
            qs = (s == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rsp_unexpected dut%0d: got response %h, required none", s, rs_d[s]);
            end else begin
                if (s == 0) x = q0.pop_front(); else x = q1.pop_front();
                chk($sformatf("model_data dut%0d", s), rs_d[s], x.d);
                chk($sformatf("model_err dut%0d", s), 32'(rs_e[s]), 32'(x.e));
                if (chk_lat[s]) chk($sformatf("latency dut%0d", s), 32'(cyc - x.c), 32'(s + 1));
            end
        end
        if (rq_v[s] && rq_rdy[s]) begin
            model(s, rq_w[s], rq_a[s], rq_be[s], rq_d[s], rq_sx[s], rd, er);
            x.d = rd;
            x.e = er;
            x.c = cyc;
            if (s == 0) q0.push_back(x); else q1.push_back(x);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
        if (rst[0] && u_a.w_push && u_a.r_fcnt == 2) begin
            n_bad++;
            $display("FAIL fifo_overflow dut0: push with count %0d, required < 2", u_a.r_fcnt);
        end
        if (rst[1] && u_b.w_push && u_b.r_fcnt == 3) begin
            n_bad++;
            $display("FAIL fifo_overflow dut1: push with count %0d, required < 3", u_b.r_fcnt);
        end
    end

    task automatic issue(input int s, input logic w, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d, input logic sx);
        bit ok;
        ok = 0;
        rq_v[s] = 1'b1; rq_w[s] = w; rq_a[s] = a; rq_be[s] = be; rq_d[s] = d; rq_sx[s] = sx;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rq_rdy[s]) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        rq_v[s] = 1'b0;
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL issue_timeout dut%0d: ReqReady stayed 0, required 1", s);
        end
    endtask

    task automatic get_rsp(input int s, output logic [31:0] d, output logic e);
        bit ok;
        ok = 0;
        d = '0;
        e = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rs_v[s] && rs_r[s]) begin d = rs_d[s]; e = rs_e[s]; ok = 1; break; end
        end
        @(posedge clk); #1;
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL rsp_timeout dut%0d: RspValid stayed 0, required 1", s);
        end
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        logic        sx;
        logic [31:0] xd;
        logic        xe;
    } vec_t;

    vec_t tv[$];

    task automatic random_phase(input int s);
        int t0;
        int unsigned sz;
        logic [3:0] be;
        logic [31:0] a;
        logic [31:0] sa;
        chk_lat[s] = 1'b1;
        for (int k = 0; k < 16; k++) issue(s, 1'b1, 32'(4 * k), 4'hF, $urandom, 1'b0);
        t0 = cyc;
        for (int k = 0; k < 100; k++) begin
            case ($urandom_range(0, 2))
                0:       begin sz = 1; be = 4'h1; end
                1:       begin sz = 2; be = 4'h3; end
                default: begin sz = 4; be = 4'hF; end
            endcase
            sa = 32'($urandom_range(0, 64 / sz - 1) * sz);
            issue(s, 1'b1, sa, be, $urandom, 1'b0);
            case ($urandom_range(0, 2))
                0:       begin sz = 1; be = 4'h1; end
                1:       begin sz = 2; be = 4'h3; end
                default: begin sz = 4; be = 4'hF; end
            endcase
            if ($urandom_range(0, 1) == 0) a = sa & ~32'(sz - 1);
            else a = 32'($urandom_range(0, 64 / sz - 1) * sz);
            if ($urandom_range(0, 7) == 0) begin
                a  = 32'($urandom_range(0, 70));
                be = 4'($urandom);
            end
            issue(s, 1'b0, a, be, 32'h0, 1'($urandom));
        end
        chk($sformatf("throughput dut%0d", s), 32'(cyc - t0), 32'd200);
        repeat (6) @(posedge clk);
        #1;
        chk($sformatf("drained dut%0d", s), 32'((s == 0) ? q0.size() : q1.size()), 32'd0);
        chk_lat[s] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic e;
        int acc;
        logic [31:0] a;

        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; rq_v[s] = 1'b0; rq_w[s] = 1'b0; rq_a[s] = '0; rq_be[s] = '0;
            rq_d[s] = '0; rq_sx[s] = 1'b0; rs_r[s] = 1'b1; chk_lat[s] = 1'b0;
        end
        #2;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Reset values with random inputs
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            for (int s = 0; s < 2; s++) begin
                rq_v[s] = 1'($urandom); rq_w[s] = 1'($urandom); rq_a[s] = $urandom;
                rq_be[s] = 4'($urandom); rq_d[s] = $urandom; rq_sx[s] = 1'($urandom);
                rs_r[s] = 1'($urandom);
            end
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                chk($sformatf("rst_ReqReady dut%0d", s), 32'(rq_rdy[s]), 32'd0);
                chk($sformatf("rst_RspValid dut%0d", s), 32'(rs_v[s]), 32'd0);
                chk($sformatf("rst_RspRdData dut%0d", s), rs_d[s], 32'd0);
                chk($sformatf("rst_RspError dut%0d", s), 32'(rs_e[s]), 32'd0);
            end
        end
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            rq_v[s] = 1'b0; rs_r[s] = 1'b1; rst[s] = 1'b1;
        end
        @(posedge clk); #1;
        chk("post_rst_ReqReady dut0", 32'(rq_rdy[0]), 32'd1);
        chk("post_rst_ReqReady dut1", 32'(rq_rdy[1]), 32'd1);

        // Directed table on the LATENCY=1 instance
        tv.push_back('{1'b1, 32'h10,       4'hF, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0});
        tv.push_back('{1'b0, 32'h13,       4'h1, 32'h0,        1'b1, 32'hFFFFFFDE, 1'b0});
        tv.push_back('{1'b0, 32'h12,       4'h3, 32'h0,        1'b0, 32'h0000DEAD, 1'b0});
        tv.push_back('{1'b0, 32'h10,       4'h1, 32'h0,        1'b1, 32'hFFFFFFEF, 1'b0});
        tv.push_back('{1'b0, 32'h11,       4'h1, 32'h0,        1'b0, 32'h000000BE, 1'b0});
        tv.push_back('{1'b0, 32'h10,       4'h3, 32'h0,        1'b1, 32'hFFFFBEEF, 1'b0});
        tv.push_back('{1'b0, 32'h10,       4'hF, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0});
        tv.push_back('{1'b0, 32'h11,       4'hF, 32'h0,        1'b0, 32'h00000000, 1'b1});
        tv.push_back('{1'b1, 32'h20,       4'hF, 32'hA5A5A5A5, 1'b0, 32'h00000000, 1'b0});
        tv.push_back('{1'b1, 32'h20,       4'h5, 32'h11223344, 1'b0, 32'h00000000, 1'b1});
        tv.push_back('{1'b0, 32'h20,       4'hF, 32'h0,        1'b0, 32'hA5A5A5A5, 1'b0});
        tv.push_back('{1'b1, 32'h21,       4'h1, 32'h0000007F, 1'b0, 32'h00000000, 1'b0});
        tv.push_back('{1'b0, 32'h20,       4'h3, 32'h0,        1'b1, 32'h00007FA5, 1'b0});
        tv.push_back('{1'b0, 32'h22,       4'h3, 32'h0,        1'b1, 32'hFFFFA5A5, 1'b0});
        tv.push_back('{1'b0, 32'hFFE,      4'hF, 32'h0,        1'b0, 32'h00000000, 1'b1});
        tv.push_back('{1'b1, 32'hFFE,      4'h3, 32'h00001234, 1'b0, 32'h00000000, 1'b0});
        tv.push_back('{1'b0, 32'hFFE,      4'h3, 32'h0,        1'b0, 32'h00001234, 1'b0});
        tv.push_back('{1'b0, 32'hFFF,      4'h1, 32'h0,        1'b1, 32'h00000012, 1'b0});
        tv.push_back('{1'b0, 32'h1000,     4'h1, 32'h0,        1'b0, 32'h00000000, 1'b1});
        tv.push_back('{1'b0, 32'hFFFFFFFF, 4'h1, 32'h0,        1'b0, 32'h00000000, 1'b1});
        tv.push_back('{1'b0, 32'h10,       4'h0, 32'h0,        1'b0, 32'h00000000, 1'b1});
        tv.push_back('{1'b1, 32'h14,       4'hC, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1});
        tv.push_back('{1'b0, 32'h11,       4'h3, 32'h0,        1'b0, 32'h00000000, 1'b1});
        tv.push_back('{1'b1, 32'hFFC,      4'hF, 32'hCAFEF00D, 1'b0, 32'h00000000, 1'b0});
        tv.push_back('{1'b0, 32'hFFC,      4'hF, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0});
        for (int i = 0; i < tv.size(); i++) begin
            issue(0, tv[i].w, tv[i].a, tv[i].be, tv[i].d, tv[i].sx);
            get_rsp(0, d, e);
            chk($sformatf("tv%0d_data", i), d, tv[i].xd);
            chk($sformatf("tv%0d_err", i), 32'(e), 32'(tv[i].xe));
        end

        // Reset mid-operation with two responses queued
        rs_r[0] = 1'b0;
        issue(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
        issue(0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0);
        chk("queued_RspValid", 32'(rs_v[0]), 32'd1);
        rst[0] = 1'b0;
        #1;
        chk("async_RspValid", 32'(rs_v[0]), 32'd0);
        chk("async_ReqReady", 32'(rq_rdy[0]), 32'd0);
        chk("async_RspRdData", rs_d[0], 32'd0);
        @(posedge clk); #1;
        rst[0] = 1'b1;
        @(negedge clk);
        chk("lost_RspValid", 32'(rs_v[0]), 32'd0);
        @(posedge clk); #1;
        chk("rerelease_ReqReady", 32'(rq_rdy[0]), 32'd1);
        rs_r[0] = 1'b1;
        issue(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
        get_rsp(0, d, e);
        chk("reload_0x10", d, 32'hDEADBEEF);
        issue(0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0);
        get_rsp(0, d, e);
        chk("reload_0x20", d, 32'hA5A57FA5);

        // Back-pressure on the LATENCY=2 instance
        for (int k = 0; k < 8; k++) issue(1, 1'b1, 32'(4 * k), 4'hF, 32'h10000000 + 32'(k) * 32'h01010101, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rs_r[1] = 1'b0;
        acc = 0;
        a = 32'h0;
        rq_v[1] = 1'b1; rq_w[1] = 1'b0; rq_be[1] = 4'hF; rq_sx[1] = 1'b0; rq_a[1] = a;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rq_v[1] && rq_rdy[1]) begin
                acc++;
                a = a + 32'd4;
            end
            @(posedge clk); #1;
            rq_a[1] = a;
            if (acc == 5) rq_v[1] = 1'b0;
        end
        chk("bp_accepted", 32'(acc), 32'd3);
        @(negedge clk);
        chk("bp_ReqReady_low", 32'(rq_rdy[1]), 32'd0);
        chk("bp_hold_data0", rs_d[1], 32'h10000000);
        @(negedge clk);
        chk("bp_hold_data1", rs_d[1], 32'h10000000);
        chk("bp_hold_valid", 32'(rs_v[1]), 32'd1);
        @(posedge clk); #1;
        rq_v[1] = 1'b0;
        rs_r[1] = 1'b1;
        @(negedge clk);
        chk("bp_first_fire_valid", 32'(rs_v[1]), 32'd1);
        chk("bp_ReqReady_still_low", 32'(rq_rdy[1]), 32'd0);
        @(negedge clk);
        chk("bp_ReqReady_reassert", 32'(rq_rdy[1]), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_drained", 32'(q1.size()), 32'd0);

        // Random back-to-back store/load traffic on both instances
        random_phase(0);
        random_phase(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
